// File: rtl/radar_trig_timebase.sv
// radar_trig_timebase
//   Front-end timing stage for the azimuth/MT generators. It synchronises the
//   external radar trigger, rejects re-triggers inside a lockout window, produces
//   a microsecond tick that is re-phased on every accepted trigger, measures the
//   trigger period in microseconds and flags a lost trigger.
//
// Ports
//   SYS_CLK        in   system clock
//   SYS_RESETN     in   asynchronous active-low reset
//   RADAR_TRIG     in   raw trigger, asynchronous to SYS_CLK
//   RADAR_TRIG_PE  out  one-cycle pulse per accepted trigger
//   USEC_PE        out  one-cycle pulse every CLK_PER_USEC cycles
//   TRIG_PERIOD    out  usec between the last two accepted triggers
//   PERIOD_VALID   out  TRIG_PERIOD holds a real measurement
//   TRIG_LOST      out  no accepted trigger for TIMEOUT_USEC usec
//   TRIG_REJECTED  out  one-cycle pulse when an edge falls inside the lockout
module radar_trig_timebase #(
    parameter int unsigned CLK_PER_USEC  = 100,
    parameter int unsigned MIN_TRIG_USEC = 100,
    parameter int unsigned TIMEOUT_USEC  = 20000,
    parameter int unsigned PW            = 16
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RESETN,
    input  logic          RADAR_TRIG,
    output logic          RADAR_TRIG_PE,
    output logic          USEC_PE,
    output logic [PW-1:0] TRIG_PERIOD,
    output logic          PERIOD_VALID,
    output logic          TRIG_LOST,
    output logic          TRIG_REJECTED
);

    localparam int unsigned    PSW     = (CLK_PER_USEC > 1) ? $clog2(CLK_PER_USEC) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(CLK_PER_USEC - 1);
    localparam logic [PW-1:0]  CNT_MAX = '1;
    localparam logic [PW-1:0]  MIN_CNT = PW'(MIN_TRIG_USEC);
    localparam logic [PW-1:0]  TMO_CNT = PW'(TIMEOUT_USEC);

    typedef enum logic [1:0] {StIdle, StLockout, StArmed} state_e;

    state_e         state_q, state_d;
    logic           sync_s1_q, sync_s2_q, sync_prev_q;
    logic [PSW-1:0] presc_q;
    logic [PW-1:0]  usec_cnt_q;

    logic edge_det;
    logic accept;    // edge taken as a new reference trigger
    logic capture;   // accepted edge that also closes a period measurement
    logic reject;    // edge dropped by the lockout
    logic tmo_hit;   // armed too long without an edge
    logic tick;      // prescaler wrap not pre-empted by an accepted trigger

    assign edge_det = sync_s2_q & ~sync_prev_q;
    // An accepted trigger re-phases the prescaler, so it swallows a coincident tick.
    assign tick     = (presc_q == PS_LAST) && !accept;

    // State register
    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StLockout;
            end
            StLockout: begin
                if (accept)                        state_d = StLockout;
                else if (usec_cnt_q >= MIN_CNT)    state_d = StArmed;
            end
            StArmed: begin
                if (accept)       state_d = StLockout;
                else if (tmo_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM decode. LOCKOUT with the counter already at the limit behaves as ARMED,
    // covering the single cycle before the registered state catches up.
    always_comb begin
        accept  = 1'b0;
        capture = 1'b0;
        reject  = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                accept = edge_det;
            end
            StLockout: begin
                if (usec_cnt_q < MIN_CNT) begin
                    reject = edge_det;
                end else begin
                    accept  = edge_det;
                    capture = edge_det;
                end
            end
            StArmed: begin
                accept  = edge_det;
                capture = edge_det;
                // An edge in the timeout cycle wins.
                tmo_hit = !edge_det && (usec_cnt_q >= TMO_CNT);
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            sync_s1_q     <= 1'b0;
            sync_s2_q     <= 1'b0;
            sync_prev_q   <= 1'b0;
            presc_q       <= '0;
            usec_cnt_q    <= '0;
            RADAR_TRIG_PE <= 1'b0;
            USEC_PE       <= 1'b0;
            TRIG_PERIOD   <= '0;
            PERIOD_VALID  <= 1'b0;
            TRIG_LOST     <= 1'b0;
            TRIG_REJECTED <= 1'b0;
        end else begin
            sync_s1_q     <= RADAR_TRIG;
            sync_s2_q     <= sync_s1_q;
            sync_prev_q   <= sync_s2_q;
            RADAR_TRIG_PE <= accept;
            TRIG_REJECTED <= reject;
            USEC_PE       <= tick;

            if (accept || (presc_q == PS_LAST)) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PSW'(1);
            end

            if (accept) begin
                usec_cnt_q <= '0;
            end else if (tick && (usec_cnt_q != CNT_MAX)) begin
                usec_cnt_q <= usec_cnt_q + PW'(1);
            end

            if (capture) begin
                TRIG_PERIOD  <= usec_cnt_q;
                PERIOD_VALID <= 1'b1;
            end else if (tmo_hit) begin
                PERIOD_VALID <= 1'b0;
            end

            if (accept) begin
                TRIG_LOST <= 1'b0;
            end else if (tmo_hit) begin
                TRIG_LOST <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_radar_trig_timebase.sv
// Testbench for radar_trig_timebase: random and directed trigger timing against a
// time-based reference model, with a queue-fed monitor checking every cycle.
module tb_radar_trig_timebase;

    localparam int N   = 10;   // clocks per usec
    localparam int MIN = 20;   // lockout, usec
    localparam int TMO = 150;  // timeout, usec
    localparam int PW  = 10;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic          trig = 1'b0;
    logic          pe, usec, valid, lost, rej;
    logic [PW-1:0] period;

    radar_trig_timebase #(
        .CLK_PER_USEC (N),
        .MIN_TRIG_USEC(MIN),
        .TIMEOUT_USEC (TMO),
        .PW           (PW)
    ) dut (
        .SYS_CLK      (clk),
        .SYS_RESETN   (rstn),
        .RADAR_TRIG   (trig),
        .RADAR_TRIG_PE(pe),
        .USEC_PE      (usec),
        .TRIG_PERIOD  (period),
        .PERIOD_VALID (valid),
        .TRIG_LOST    (lost),
        .TRIG_REJECTED(rej)
    );

    always #5 clk = ~clk;

    // Expected trigger-path event, keyed by the cycle it must appear in.
    typedef struct {
        int cyc;
        bit acc;     // 1: RADAR_TRIG_PE, 0: TRIG_REJECTED
        bit armed;   // acceptance that captures a period
        int period;
        bit valid;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   in_reset = 1'b1;

    // Stimulus-side model: cycle of last acceptance (or reset origin) and
    // whether a reference trigger exists.
    int s_L   = 0;
    bit s_ref = 1'b0;

    // Monitor-side state
    int   m_L      = 0;
    bit   m_ref    = 1'b0;
    bit   m_lost   = 1'b0;
    bit   m_valid  = 1'b0;
    int   m_period = 0;
    bit   e_acc, e_rej, e_usec;
    exp_t m_e;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: sampled 3 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            if (in_reset) begin
                m_L      = cyc;
                m_ref    = 1'b0;
                m_lost   = 1'b0;
                m_valid  = 1'b0;
                m_period = 0;
                q.delete();
                continue;
            end
            e_acc = 1'b0;
            e_rej = 1'b0;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                m_e = q.pop_front();
                if (m_e.acc) begin
                    e_acc   = 1'b1;
                    m_L     = cyc;
                    m_ref   = 1'b1;
                    m_lost  = 1'b0;
                    m_valid = m_e.valid;
                    if (m_e.armed) m_period = m_e.period;
                end else begin
                    e_rej = 1'b1;
                end
            end else if (m_ref && (cyc - m_L == N * TMO + 1)) begin
                m_lost  = 1'b1;
                m_valid = 1'b0;
                m_ref   = 1'b0;
            end
            e_usec = (cyc > m_L) && ((cyc - m_L) % N == 0);
            check("RADAR_TRIG_PE", pe, e_acc);
            check("TRIG_REJECTED", rej, e_rej);
            check("USEC_PE", usec, e_usec);
            check("TRIG_LOST", lost, m_lost);
            check("PERIOD_VALID", valid, m_valid);
            check("TRIG_PERIOD", period, m_period);
        end
    end

    // Assert reset (any phase), confirm outputs cleared at once, release on a falling edge.
    task automatic do_reset();
        in_reset = 1'b1;
        rstn     = 1'b0;
        trig     = 1'b0;
        #1;
        check("rst_RADAR_TRIG_PE", pe, 0);
        check("rst_USEC_PE", usec, 0);
        check("rst_TRIG_PERIOD", period, 0);
        check("rst_PERIOD_VALID", valid, 0);
        check("rst_TRIG_LOST", lost, 0);
        check("rst_TRIG_REJECTED", rej, 0);
        repeat (3) @(negedge clk);
        rstn     = 1'b1;
        in_reset = 1'b0;
        s_L      = cyc;
        s_ref    = 1'b0;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Raise the trigger on this falling edge; predict the outcome from elapsed time.
    task automatic fire(input int hold);
        int   c, el;
        exp_t e;
        c       = cyc + 3;
        trig    = 1'b1;
        e.cyc   = c;
        e.acc   = 1'b1;
        e.armed = 1'b0;
        e.period = 0;
        e.valid = 1'b0;
        if (s_ref) begin
            el = (c - 1 - s_L) / N;  // usec ticks seen before the decision cycle
            if (el < MIN) begin
                e.acc = 1'b0;
            end else if (c - 1 - s_L <= N * TMO) begin
                e.armed  = 1'b1;
                e.period = el;
                e.valid  = 1'b1;
            end
        end
        if (e.acc) begin
            s_L   = c;
            s_ref = 1'b1;
        end
        q.push_back(e);
        repeat (hold) @(negedge clk);
        trig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d;
        do_reset();
        repeat (100) @(negedge clk);                  // idle ticks only

        repeat ($urandom_range(0, 9)) @(negedge clk); // arbitrary phase
        fire(2);                                      // IDLE acceptance
        wait_to(s_L + N * 50 + 4 - 3);  fire(1);      // period 50
        wait_to(s_L + N * 50 + 7 - 3);  fire(3);      // period 50 again
        wait_to(s_L + N * 5 - 3);       fire(1);      // inside lockout
        wait_to(s_L + N * MIN - 3);     fire(1);      // last rejected cycle
        wait_to(s_L + N * 60 - 3);      fire(1);      // lands on prescaler wrap
        wait_to(s_L + N * MIN - 2);     fire(1);      // first accepted cycle
        fire(300);                                    // level: one edge only
        wait_to(s_L + N * TMO - 2);     fire(1);      // edge beats timeout
        wait_to(s_L + N * TMO - 1);     fire(1);      // one cycle after timeout
        wait_to(s_L + N * TMO + 40);    fire(1);      // well after timeout
        wait_to(s_L + N * 30 + 1);      fire(1);      // valid again

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      d = $urandom_range(4, N * MIN);
            else if (r < 9) d = $urandom_range(N * MIN - 2, N * TMO + 2);
            else            d = $urandom_range(N * TMO, N * TMO + 200);
            wait_to(s_L + d - 3);
            fire($urandom_range(1, 5));
        end

        // Asynchronous reset mid-count, then IDLE acceptance and a fresh measurement.
        wait_to(s_L + N * 40 + 3); fire(1);
        repeat (37) @(negedge clk);
        @(posedge clk);
        #2;
        do_reset();
        repeat (23) @(negedge clk);
        fire(1);
        wait_to(s_L + N * 25 - 3); fire(1);

        repeat (10) @(negedge clk);
        check("pending_events", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
